alpha_dot_accumulator: RTL and testbench

Parametrised fixed-point successor to the floating-point alpha calculator in the hardware LPC/Levinson-Durbin path. Each enabled beat accepts LANES (ACF, model) coefficient pairs and multiplies them pairwise. It accumulates the products across a burst of valid beats. At burst end it emits the rounded, optionally negated, saturated dot product as alpha with a done pulse. It feeds the reflection-coefficient stage.

---
 rtl/alpha_pkg.sv | 31 +++
 rtl/lane_mac_tree.sv | 33 +++
 rtl/alpha_dot_accumulator.sv | 77 +++++++
 tb/tb_alpha_dot_accumulator.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alpha_pkg.sv
// alpha_pkg: shared defaults, lane slicing and rounding/saturation for alpha_dot_accumulator
// Exports default parameter values, lane_lsb() for locating a lane in a packed bus,
// and round_sat(), which maps a Q.2FRAC sum to a saturated Q.FRAC word of a given width.
package alpha_pkg;
  localparam int DEF_LANES = 2;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_FRAC = 16;
  localparam int DEF_ACC_WIDTH = 72;
  // Working width for round_sat; wide enough that rounding and negation never overflow.
  localparam int MAX_ACC = 256;
  typedef struct packed {
    logic sat;
    logic [MAX_ACC-1:0] val;
  } fmt_t;
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction
  function automatic fmt_t round_sat(input logic signed [MAX_ACC-1:0] acc, input int frac, input int width, input logic neg);
    logic signed [MAX_ACC-1:0] one, r, hi, lo;
    fmt_t f;
    one = MAX_ACC'(1);
    // Adding half an output LSB before the arithmetic shift rounds half toward +inf.
    r = (acc + (one <<< (frac - 1))) >>> frac;
    r = neg ? -r : r;
    hi = (one <<< (width - 1)) - one;
    lo = -(one <<< (width - 1));
    f.sat = (r > hi) || (r < lo);
    f.val = (r > hi) ? hi : (r < lo) ? lo : r;
    return f;
  endfunction
endpackage

// File: rtl/lane_mac_tree.sv
// lane_mac_tree: registered per-lane signed products followed by a registered adder tree
// Ports: clk/rst (sync, active-high)/en clock enable; acf/model packed LANES x WIDTH lanes;
// sum is the ACC_WIDTH sign-extended sum of lane products, two enabled edges after the inputs.
module lane_mac_tree
  import alpha_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int WIDTH = DEF_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [LANES*WIDTH-1:0]      acf,
  input  logic [LANES*WIDTH-1:0]      model,
  output logic signed [ACC_WIDTH-1:0] sum
);
  logic signed [2*WIDTH-1:0] prod [LANES];
  logic signed [ACC_WIDTH-1:0] tree;
  always_comb begin
    tree = '0;
    for (int i = 0; i < LANES; i++) tree = tree + ACC_WIDTH'(prod[i]);
  end
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < LANES; i++) prod[i] <= '0;
      sum <= '0;
    end else if (en) begin
      for (int i = 0; i < LANES; i++)
        prod[i] <= $signed(acf[lane_lsb(i, WIDTH) +: WIDTH]) * $signed(model[lane_lsb(i, WIDTH) +: WIDTH]);
      sum <= tree;
    end
endmodule

// File: rtl/alpha_dot_accumulator.sv
// alpha_dot_accumulator: fixed-point burst dot product of ACF and model coefficients for the LPC alpha term
// Ports: iClock, iReset (sync, active-high), iEnable clock enable, iValid beat qualifier,
// iNegate (taken on a burst's first beat), iACF/iModel packed LANES x WIDTH signed Q.FRAC lanes;
// oAlpha rounded saturated result, oDone result strobe, oSat clip flag, oBusy pipeline occupied.
module alpha_dot_accumulator
  import alpha_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC = DEF_FRAC,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                   iClock,
  input  logic                   iReset,
  input  logic                   iEnable,
  input  logic                   iValid,
  input  logic                   iNegate,
  input  logic [LANES*WIDTH-1:0] iACF,
  input  logic [LANES*WIDTH-1:0] iModel,
  output logic [WIDTH-1:0]       oAlpha,
  output logic                   oDone,
  output logic                   oSat,
  output logic                   oBusy
);
  logic prev_valid;
  logic s1_v, s1_first, s1_neg;
  logic [LANES*WIDTH-1:0] s1_acf, s1_model;
  logic s2_v, s2_first, s2_last, s2_neg;
  logic s3_v, s3_first, s3_last, s3_neg;
  logic s4_v, s4_last, s4_neg;
  logic signed [ACC_WIDTH-1:0] sum, acc;
  fmt_t fmt;
  wire first = iValid & ~prev_valid;
  lane_mac_tree #(.LANES(LANES), .WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_tree (
    .clk(iClock),
    .rst(iReset),
    .en(iEnable),
    .acf(s1_acf),
    .model(s1_model),
    .sum(sum)
  );
  always_comb fmt = round_sat({{(MAX_ACC-ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc}, FRAC, WIDTH, s4_neg);
  assign oBusy = s1_v | s2_v | s3_v | s4_v;
  always_ff @(posedge iClock)
    if (iReset) begin
      prev_valid <= 1'b0;
      s1_v <= 1'b0;
      s1_first <= 1'b0;
      s1_neg <= 1'b0;
      s1_acf <= '0;
      s1_model <= '0;
      {s2_v, s2_first, s2_last, s2_neg} <= '0;
      {s3_v, s3_first, s3_last, s3_neg} <= '0;
      {s4_v, s4_last, s4_neg} <= '0;
      acc <= '0;
      oAlpha <= '0;
      oDone <= 1'b0;
      oSat <= 1'b0;
    end else if (iEnable) begin
      prev_valid <= iValid;
      s1_v <= iValid;
      s1_first <= first;
      s1_neg <= first ? iNegate : s1_neg;
      s1_acf <= iACF;
      s1_model <= iModel;
      // A beat is known to be last only when the following enabled cycle is idle.
      {s2_v, s2_first, s2_last, s2_neg} <= {s1_v, s1_first, s1_v & ~iValid, s1_neg};
      {s3_v, s3_first, s3_last, s3_neg} <= {s2_v, s2_first, s2_last, s2_neg};
      {s4_v, s4_last, s4_neg} <= {s3_v, s3_last, s3_neg};
      if (s3_v) acc <= s3_first ? sum : acc + sum;
      oDone <= s4_v & s4_last;
      if (s4_v & s4_last) begin
        oAlpha <= fmt.val[WIDTH-1:0];
        oSat <= fmt.sat;
      end
    end
endmodule

// File: tb/tb_alpha_dot_accumulator.sv
// tb_alpha_dot_accumulator: directed and randomized self-checking bench for alpha_dot_accumulator
module tb_alpha_dot_accumulator;
  logic clk = 1'b0;
  logic iReset, iEnable, iValid, iNegate;
  logic [63:0] iACF, iModel;
  logic [31:0] oAlpha;
  logic oDone, oSat, oBusy;
  int total = 0;
  int bad = 0;

  localparam logic [63:0] ACF1 = {32'h00008000, 32'hFFFF8000};
  localparam logic [63:0] MOD1 = {32'h00040000, 32'h00020000};
  localparam logic [63:0] MAXV = {32'h7FFFFFFF, 32'h7FFFFFFF};
  localparam logic [63:0] ACFH = {32'h00000000, 32'h00008000};
  localparam logic [63:0] MODH = {32'h00000000, 32'h00010000};

  typedef struct {
    logic en;
    logic v;
    logic n;
    logic [63:0] a;
    logic [63:0] m;
  } step_t;

  always #5 clk = ~clk;

  alpha_dot_accumulator dut (
    .iClock(clk),
    .iReset(iReset),
    .iEnable(iEnable),
    .iValid(iValid),
    .iNegate(iNegate),
    .iACF(iACF),
    .iModel(iModel),
    .oAlpha(oAlpha),
    .oDone(oDone),
    .oSat(oSat),
    .oBusy(oBusy)
  );

  // Reference: exact sum of lane products, rounded half up to FRAC=16, optional negate, clip to 32 bits.
  function automatic logic [32:0] ref_alpha(input logic [63:0] a[$], input logic [63:0] m[$], input logic neg);
    logic signed [127:0] s, x, y, r;
    s = '0;
    for (int b = 0; b < a.size(); b++)
      for (int l = 0; l < 2; l++) begin
        x = 128'(signed'(a[b][l*32 +: 32]));
        y = 128'(signed'(m[b][l*32 +: 32]));
        s = s + x * y;
      end
    r = (s + 128'sd32768) >>> 16;
    if (neg) r = -r;
    if (r > 128'sh7FFFFFFF) return {1'b1, 32'h7FFFFFFF};
    if (r < -128'sh80000000) return {1'b1, 32'h80000000};
    return {1'b0, r[31:0]};
  endfunction

  function automatic logic [31:0] rnd();
    logic [31:0] v;
    v = $urandom;
    return ($urandom_range(0, 3) == 0) ? v : {{12{v[31]}}, v[31:12]};
  endfunction

  task automatic cyc(input logic en, input logic v, input logic n, input logic [63:0] a, input logic [63:0] m);
    iEnable = en;
    iValid = v;
    iNegate = n;
    iACF = a;
    iModel = m;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      cyc(1'b1, 1'b0, 1'b0, '0, '0);
      if (oDone) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    iReset = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, MAXV, MAXV);
    cyc(1'b1, 1'b1, 1'b0, ACF1, MOD1);
    total += 4;
    if (oAlpha !== 32'h0) begin bad++; $display("FAIL reset_alpha: got %h expected 00000000", oAlpha); end
    if (oDone !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", oDone); end
    if (oSat !== 1'b0) begin bad++; $display("FAIL reset_sat: got %b expected 0", oSat); end
    if (oBusy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", oBusy); end
    iReset = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_single();
    int n;
    cyc(1'b1, 1'b1, 1'b0, ACF1, MOD1);
    total++;
    if (oBusy !== 1'b1) begin bad++; $display("FAIL single_busy_rise: got %b expected 1", oBusy); end
    wait_done(12, n);
    total += 5;
    if (n !== 4) begin bad++; $display("FAIL single_latency: got %0d expected 4", n); end
    if (oAlpha !== 32'h00010000) begin bad++; $display("FAIL single_alpha: got %h expected 00010000", oAlpha); end
    if (oSat !== 1'b0) begin bad++; $display("FAIL single_sat: got %b expected 0", oSat); end
    if (oBusy !== 1'b0) begin bad++; $display("FAIL single_busy_fall: got %b expected 0", oBusy); end
    cyc(1'b1, 1'b0, 1'b0, '0, '0);
    if (oDone !== 1'b0) begin bad++; $display("FAIL single_pulse: got %b expected 0", oDone); end
  endtask

  task automatic test_negate();
    int n;
    cyc(1'b1, 1'b1, 1'b1, ACF1, MOD1);
    wait_done(12, n);
    total += 3;
    if (n !== 4) begin bad++; $display("FAIL negate_latency: got %0d expected 4", n); end
    if (oAlpha !== 32'hFFFF0000) begin bad++; $display("FAIL negate_alpha: got %h expected ffff0000", oAlpha); end
    if (oSat !== 1'b0) begin bad++; $display("FAIL negate_sat: got %b expected 0", oSat); end
  endtask

  task automatic test_enable_gap();
    int n;
    cyc(1'b1, 1'b1, 1'b0, ACF1, MOD1);
    cyc(1'b0, 1'b1, 1'b1, MAXV, MAXV);
    cyc(1'b0, 1'b1, 1'b1, MAXV, MAXV);
    cyc(1'b1, 1'b1, 1'b1, ACF1, MOD1);
    wait_done(12, n);
    total += 2;
    if (n + 3 !== 7) begin bad++; $display("FAIL gap_latency: got %0d expected 7 cycles from first beat", n + 3); end
    if (oAlpha !== 32'h00020000) begin bad++; $display("FAIL gap_alpha: got %h expected 00020000", oAlpha); end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, 1'b0, '0, '0);
      total++;
      if (oDone !== 1'b1) begin bad++; $display("FAIL gap_done_hold: got %b expected 1", oDone); end
    end
    cyc(1'b1, 1'b0, 1'b0, '0, '0);
    total++;
    if (oDone !== 1'b0) begin bad++; $display("FAIL gap_done_drop: got %b expected 0", oDone); end
  endtask

  task automatic test_saturate();
    int n;
    cyc(1'b1, 1'b1, 1'b0, MAXV, MAXV);
    wait_done(12, n);
    total += 2;
    if (oAlpha !== 32'h7FFFFFFF) begin bad++; $display("FAIL sat_pos_alpha: got %h expected 7fffffff", oAlpha); end
    if (oSat !== 1'b1) begin bad++; $display("FAIL sat_pos_flag: got %b expected 1", oSat); end
    cyc(1'b1, 1'b1, 1'b1, MAXV, MAXV);
    wait_done(12, n);
    total += 2;
    if (oAlpha !== 32'h80000000) begin bad++; $display("FAIL sat_neg_alpha: got %h expected 80000000", oAlpha); end
    if (oSat !== 1'b1) begin bad++; $display("FAIL sat_neg_flag: got %b expected 1", oSat); end
  endtask

  task automatic test_back_to_back();
    int at[$];
    logic [31:0] val[$];
    for (int i = 0; i < 12; i++) begin
      if (i == 0) cyc(1'b1, 1'b1, 1'b0, ACF1, MOD1);
      else if (i == 2) cyc(1'b1, 1'b1, 1'b0, ACFH, MODH);
      else cyc(1'b1, 1'b0, 1'b0, '0, '0);
      if (oDone) begin
        at.push_back(i);
        val.push_back(oAlpha);
      end
    end
    total++;
    if (at.size() !== 2) begin
      bad++;
      $display("FAIL b2b_count: got %0d expected 2", at.size());
    end else begin
      total += 4;
      if (at[0] !== 4) begin bad++; $display("FAIL b2b_first_at: got %0d expected 4", at[0]); end
      if (at[1] - at[0] !== 2) begin bad++; $display("FAIL b2b_spacing: got %0d expected 2", at[1] - at[0]); end
      if (val[0] !== 32'h00010000) begin bad++; $display("FAIL b2b_first_alpha: got %h expected 00010000", val[0]); end
      if (val[1] !== 32'h00008000) begin bad++; $display("FAIL b2b_second_alpha: got %h expected 00008000", val[1]); end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int dones;
    cyc(1'b1, 1'b1, 1'b0, ACF1, MOD1);
    iReset = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, ACF1, MOD1);
    total += 4;
    if (oAlpha !== 32'h0) begin bad++; $display("FAIL rmid_alpha: got %h expected 00000000", oAlpha); end
    if (oDone !== 1'b0) begin bad++; $display("FAIL rmid_done: got %b expected 0", oDone); end
    if (oSat !== 1'b0) begin bad++; $display("FAIL rmid_sat: got %b expected 0", oSat); end
    if (oBusy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b expected 0", oBusy); end
    iReset = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 1'b0, '0, '0);
      if (oDone) dones++;
    end
    total++;
    if (dones !== 0) begin bad++; $display("FAIL rmid_no_done: got %0d expected 0", dones); end
    cyc(1'b1, 1'b1, 1'b0, ACFH, MODH);
    wait_done(12, n);
    total += 2;
    if (n !== 4) begin bad++; $display("FAIL rmid_after_latency: got %0d expected 4", n); end
    if (oAlpha !== 32'h00008000) begin bad++; $display("FAIL rmid_after_alpha: got %h expected 00008000", oAlpha); end
  endtask

  task automatic test_random();
    step_t plan[$];
    step_t s;
    logic [32:0] exp_q[$];
    logic [32:0] e;
    logic [63:0] qa[$], qm[$];
    logic neg;
    int len;
    for (int b = 0; b < 30; b++) begin
      qa.delete();
      qm.delete();
      neg = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 4);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 3) == 0) begin
          s = '{en: 1'b0, v: 1'($urandom), n: 1'($urandom), a: {$urandom, $urandom}, m: {$urandom, $urandom}};
          plan.push_back(s);
        end
        s = '{en: 1'b1, v: 1'b1, n: (j == 0) ? neg : 1'($urandom), a: {rnd(), rnd()}, m: {rnd(), rnd()}};
        plan.push_back(s);
        qa.push_back(s.a);
        qm.push_back(s.m);
      end
      s = '{en: 1'b1, v: 1'b0, n: 1'($urandom), a: {$urandom, $urandom}, m: {$urandom, $urandom}};
      plan.push_back(s);
      if ($urandom_range(0, 2) == 0) plan.push_back(s);
      exp_q.push_back(ref_alpha(qa, qm, neg));
    end
    for (int i = 0; i < 10; i++) plan.push_back('{en: 1'b1, v: 1'b0, n: 1'b0, a: '0, m: '0});
    foreach (plan[i]) begin
      cyc(plan[i].en, plan[i].v, plan[i].n, plan[i].a, plan[i].m);
      if (plan[i].en && oDone) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rand_extra_done: got alpha %h with no result expected", oAlpha);
        end else begin
          e = exp_q.pop_front();
          if ({oSat, oAlpha} !== e) begin
            bad++;
            $display("FAIL rand_result: got sat=%b alpha=%h expected sat=%b alpha=%h", oSat, oAlpha, e[32], e[31:0]);
          end
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL rand_missing_done: got %0d results short expected 0", exp_q.size()); end
  endtask

  initial begin
    iReset = 1'b1;
    iEnable = 1'b0;
    iValid = 1'b0;
    iNegate = 1'b0;
    iACF = '0;
    iModel = '0;
    test_reset();
    test_single();
    test_negate();
    test_enable_gap();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
